// File: rtl/camera_bin2x2.sv
// rtl/camera_bin2x2.sv - 2x2 pixel binning stage behind the camera capture block
// Even-line horizontal pair sums are parked in a half-width line buffer and combined with the odd line.
module camera_bin2x2 #(
    parameter int HEIGHT    = 480,
    parameter int WIDTH     = 752,
    parameter int LINE_BITS = (HEIGHT > 1) ? $clog2(HEIGHT) : 1,
    parameter int COL_BITS  = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    localparam int OL_BITS  = (LINE_BITS > 1) ? LINE_BITS - 1 : 1,
    localparam int OC_BITS  = (COL_BITS > 1) ? COL_BITS - 1 : 1
) (
    input  logic                 PIXCLK,
    input  logic                 RESET,
    input  logic [9:0]           DATA_IN,
    input  logic [LINE_BITS-1:0] CURRENT_LINE,
    input  logic [COL_BITS-1:0]  CURRENT_COLUMN,
    input  logic                 PIXEL_VALID,
    output logic [9:0]           DATA_OUT,
    output logic [OL_BITS-1:0]   OUT_LINE,
    output logic [OC_BITS-1:0]   OUT_COLUMN,
    output logic                 OUT_VALID,
    output logic                 FRAME_DONE
);

    localparam int HALF_W = WIDTH / 2;
    localparam logic [LINE_BITS:0] LINE_LIMIT = (LINE_BITS + 1)'(2 * (HEIGHT / 2));
    localparam logic [COL_BITS:0]  COL_LIMIT  = (COL_BITS + 1)'(2 * (WIDTH / 2));
    localparam logic [OL_BITS-1:0] LAST_LINE  = OL_BITS'(HEIGHT / 2 - 1);
    localparam logic [OC_BITS-1:0] LAST_COL   = OC_BITS'(WIDTH / 2 - 1);

    logic [9:0]           hold;
    logic                 hold_valid;
    logic [HALF_W-1:0]    entry_valid;
    logic [10:0]          line_buf [HALF_W];

    logic [LINE_BITS-1:0] line_half;
    logic [COL_BITS-1:0]  col_half;
    logic [OL_BITS-1:0]   bin_line;
    logic [OC_BITS-1:0]   idx;
    logic                 in_grid;
    logic                 take;
    logic                 line_odd;
    logic                 col_odd;
    logic                 restart;
    logic                 pair_ok;
    logic                 bin_ready;
    logic                 buf_we;
    logic [10:0]          pair;
    logic [10:0]          buf_rd;
    logic [11:0]          sum;

    assign line_half = CURRENT_LINE >> 1;
    assign col_half  = CURRENT_COLUMN >> 1;
    assign bin_line  = line_half[OL_BITS-1:0];
    assign idx       = col_half[OC_BITS-1:0];
    assign line_odd  = CURRENT_LINE[0];
    assign col_odd   = CURRENT_COLUMN[0];

    // A trailing odd line or column lies outside the grid and is dropped entirely.
    assign in_grid   = ({1'b0, CURRENT_LINE} < LINE_LIMIT) && ({1'b0, CURRENT_COLUMN} < COL_LIMIT);
    assign take      = PIXEL_VALID && in_grid;
    assign restart   = take && (CURRENT_LINE == '0) && (CURRENT_COLUMN == '0);
    assign pair_ok   = take && col_odd && hold_valid;
    assign buf_we    = pair_ok && !line_odd;
    assign bin_ready = pair_ok && line_odd && entry_valid[idx];

    assign pair   = {1'b0, hold} + {1'b0, DATA_IN};
    assign buf_rd = line_buf[idx];
    assign sum    = {1'b0, buf_rd} + {1'b0, pair};

    // Storage without reset so it maps onto RAM; the valid flags carry the state.
    always_ff @(posedge PIXCLK) begin
        if (buf_we) begin
            line_buf[idx] <= pair;
        end
    end

    always_ff @(posedge PIXCLK or posedge RESET) begin
        if (RESET) begin
            hold        <= '0;
            hold_valid  <= 1'b0;
            entry_valid <= '0;
            DATA_OUT    <= '0;
            OUT_LINE    <= '0;
            OUT_COLUMN  <= '0;
            OUT_VALID   <= 1'b0;
            FRAME_DONE  <= 1'b0;
        end else begin
            OUT_VALID  <= 1'b0;
            FRAME_DONE <= 1'b0;
            if (take && !col_odd) begin
                hold       <= DATA_IN;
                hold_valid <= 1'b1;
            end else if (pair_ok) begin
                hold_valid <= 1'b0;
            end
            // Column 0 is never odd, so a restart and a pair update never collide.
            if (restart) begin
                entry_valid <= '0;
            end else if (pair_ok) begin
                entry_valid[idx] <= !line_odd;
            end
            if (bin_ready) begin
                DATA_OUT   <= sum[11:2];
                OUT_LINE   <= bin_line;
                OUT_COLUMN <= idx;
                OUT_VALID  <= 1'b1;
                FRAME_DONE <= (bin_line == LAST_LINE) && (idx == LAST_COL);
            end
        end
    end

endmodule
